// File: rtl/bram_tdp_arb_pkg.sv
// Shared types and the round-robin search helper for the true-dual-port BRAM arbiter.
package bram_tdp_arb_pkg;

    localparam int unsigned MAX_NREQ   = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned MAX_AWIDTH = 32;
    localparam int unsigned MAX_DWIDTH = 128;

    typedef struct packed {
        logic                  rce;
        logic                  wce;
        logic [MAX_AWIDTH-1:0] addr;
        logic [MAX_DWIDTH-1:0] wdata;
    } port_cmd_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] id;
    } resp_tag_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Mask bits at or above NREQ are always zero, so wrapping modulo MAX_NREQ visits the
    // live requesters in the same circular order as wrapping modulo NREQ would.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] mask,
                                      input logic [IDX_W-1:0]    ptr);
        pick_t            p;
        logic [IDX_W-1:0] idx;
        p = '0;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (mask[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/bram_tdp_rr_pick2.sv
// Combinational two-winner round-robin picker: g0 is the first valid at/after the pointer,
// g1 the next valid after g0.
module bram_tdp_rr_pick2
    import bram_tdp_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]  i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output pick_t            o_g0,
    output pick_t            o_g1
);

    logic [MAX_NREQ-1:0] w_mask;
    logic [MAX_NREQ-1:0] w_mask_g1;

    assign w_mask = MAX_NREQ'(i_valid);

    always_comb begin
        o_g0      = rr_pick(w_mask, i_ptr);
        w_mask_g1 = w_mask;
        if (o_g0.found) begin
            w_mask_g1[o_g0.idx] = 1'b0;
        end
        o_g1 = rr_pick(w_mask_g1, o_g0.idx + IDX_W'(1));
    end

endmodule

// File: rtl/bram_tdp_arbiter.sv
// Shares one true-dual-port BRAM among NREQ single-port requesters: up to two grants per
// cycle (first on port A, second on port B), read data routed back one cycle later.
module bram_tdp_arbiter
    import bram_tdp_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned DWIDTH = 36,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*AWIDTH-1:0]   req_addr,
    input  logic [NREQ*DWIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [NREQ*DWIDTH-1:0]   rsp_rdata,
    output logic                     rce_a,
    output logic                     wce_a,
    output logic [AWIDTH-1:0]        ra_a,
    output logic [AWIDTH-1:0]        wa_a,
    output logic [DWIDTH-1:0]        wd_a,
    input  logic [DWIDTH-1:0]        rq_a,
    output logic                     rce_b,
    output logic                     wce_b,
    output logic [AWIDTH-1:0]        ra_b,
    output logic [AWIDTH-1:0]        wa_b,
    output logic [DWIDTH-1:0]        wd_b,
    input  logic [DWIDTH-1:0]        rq_b,
    output logic [CNT_W-1:0]         conflict_cnt
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [AWIDTH-1:0] w_addr  [NREQ];
    logic [DWIDTH-1:0] w_wdata [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_addr[i]  = req_addr[i*AWIDTH +: AWIDTH];
        assign w_wdata[i] = req_wdata[i*DWIDTH +: DWIDTH];
    end

    logic [NREQ-1:0] w_valid;
    pick_t           w_g0;
    pick_t           w_g1;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_g0_id;
    logic [IW-1:0]   w_g1_id;
    logic [IW-1:0]   w_last_id;
    logic [IW-1:0]   w_rr_ptr_nxt;
    logic            w_conflict;
    logic            w_g1_ok;
    port_cmd_t       w_cmd_a;
    port_cmd_t       w_cmd_b;
    resp_tag_t       r_tag_a;
    resp_tag_t       r_tag_b;
    logic [CNT_W-1:0] r_conflict_cnt;
    logic            w_unused;

    // Masking with rst_n keeps every grant and RAM enable low while reset is held.
    assign w_valid = req_valid & {NREQ{rst_n}};

    bram_tdp_rr_pick2 #(
        .NREQ (NREQ)
    ) u_pick (
        .i_valid (w_valid),
        .i_ptr   (IDX_W'(r_rr_ptr)),
        .o_g0    (w_g0),
        .o_g1    (w_g1)
    );

    assign w_g0_id = w_g0.idx[IW-1:0];
    assign w_g1_id = w_g1.idx[IW-1:0];

    assign w_conflict = w_g0.found && w_g1.found
                        && (w_addr[w_g0_id] == w_addr[w_g1_id])
                        && (req_we[w_g0_id] || req_we[w_g1_id]);
    assign w_g1_ok    = w_g1.found && !w_conflict;

    assign w_last_id    = w_g1_ok ? w_g1_id : w_g0_id;
    assign w_rr_ptr_nxt = (w_last_id == IW'(NREQ - 1)) ? '0 : w_last_id + IW'(1);

    always_comb begin
        req_ready = '0;
        w_cmd_a   = '0;
        w_cmd_b   = '0;
        if (w_g0.found) begin
            req_ready[w_g0_id] = 1'b1;
            w_cmd_a.wce  = req_we[w_g0_id];
            w_cmd_a.rce  = !req_we[w_g0_id];
            w_cmd_a.addr = MAX_AWIDTH'(w_addr[w_g0_id]);
            if (req_we[w_g0_id]) begin
                w_cmd_a.wdata = MAX_DWIDTH'(w_wdata[w_g0_id]);
            end
        end
        if (w_g1_ok) begin
            req_ready[w_g1_id] = 1'b1;
            w_cmd_b.wce  = req_we[w_g1_id];
            w_cmd_b.rce  = !req_we[w_g1_id];
            w_cmd_b.addr = MAX_AWIDTH'(w_addr[w_g1_id]);
            if (req_we[w_g1_id]) begin
                w_cmd_b.wdata = MAX_DWIDTH'(w_wdata[w_g1_id]);
            end
        end
    end

    // The RAM picks read vs write address by enable, so both address buses carry the same value.
    assign rce_a = w_cmd_a.rce;
    assign wce_a = w_cmd_a.wce;
    assign ra_a  = w_cmd_a.addr[AWIDTH-1:0];
    assign wa_a  = w_cmd_a.addr[AWIDTH-1:0];
    assign wd_a  = w_cmd_a.wdata[DWIDTH-1:0];
    assign rce_b = w_cmd_b.rce;
    assign wce_b = w_cmd_b.wce;
    assign ra_b  = w_cmd_b.addr[AWIDTH-1:0];
    assign wa_b  = w_cmd_b.addr[AWIDTH-1:0];
    assign wd_b  = w_cmd_b.wdata[DWIDTH-1:0];

    assign w_unused = ^{w_cmd_a, w_cmd_b, w_g0, w_g1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_a        <= '0;
            r_tag_b        <= '0;
            r_rr_ptr       <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_tag_a.vld <= w_cmd_a.rce;
            r_tag_a.id  <= w_g0.idx;
            r_tag_b.vld <= w_cmd_b.rce;
            r_tag_b.id  <= w_g1.idx;
            if (w_g0.found) begin
                r_rr_ptr <= w_rr_ptr_nxt;
            end
            if (w_conflict && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_tag_a.vld && (r_tag_a.id == IDX_W'(i))) begin
                rsp_valid[i]                  = 1'b1;
                rsp_rdata[i*DWIDTH +: DWIDTH] = rq_a;
            end
            if (r_tag_b.vld && (r_tag_b.id == IDX_W'(i))) begin
                rsp_valid[i]                  = 1'b1;
                rsp_rdata[i*DWIDTH +: DWIDTH] = rq_b;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_bram_tdp_arbiter.sv
// Directed bench for bram_tdp_arbiter: vector table plus fairness, saturation and reset sequences.
module tb_bram_tdp_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 36;
    localparam logic [DW-1:0] Z  = '0;
    localparam logic [DW-1:0] D5 = 36'h123456789;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata, rsp_rdata;
    logic               rce_a, wce_a, rce_b, wce_b;
    logic [AW-1:0]      ra_a, wa_a, ra_b, wa_b;
    logic [DW-1:0]      wd_a, wd_b, rq_a, rq_b;
    logic [15:0]        conflict_cnt;

    logic [NREQ-1:0]    s_ready, s_rsp_valid;
    logic [NREQ*DW-1:0] s_rsp_rdata;
    logic               s_rce_a, s_wce_a, s_rce_b, s_wce_b;
    logic [AW-1:0]      s_ra_a, s_wa_a, s_ra_b, s_wa_b;
    logic [DW-1:0]      s_wd_a, s_wd_b;
    logic [1:0]         s_cnt;

    bram_tdp_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rce_a(rce_a), .wce_a(wce_a), .ra_a(ra_a), .wa_a(wa_a), .wd_a(wd_a), .rq_a(rq_a),
        .rce_b(rce_b), .wce_b(wce_b), .ra_b(ra_b), .wa_b(wa_b), .wd_b(wd_b), .rq_b(rq_b),
        .conflict_cnt(conflict_cnt)
    );

    // Narrow-counter copy sharing all inputs; only its counter is checked.
    bram_tdp_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata),
        .rce_a(s_rce_a), .wce_a(s_wce_a), .ra_a(s_ra_a), .wa_a(s_wa_a), .wd_a(s_wd_a),
        .rq_a(rq_a),
        .rce_b(s_rce_b), .wce_b(s_wce_b), .ra_b(s_ra_b), .wa_b(s_wa_b), .wd_b(s_wd_b),
        .rq_b(rq_b),
        .conflict_cnt(s_cnt)
    );

    logic [DW-1:0] mem [1024];
    logic          tb_load;
    always @(posedge clk) begin
        if (tb_load) mem[10'h005] <= D5;
        if (wce_a) mem[wa_a] <= wd_a;
        if (wce_b) mem[wa_b] <= wd_b;
        if (rce_a) rq_a <= mem[ra_a];
        if (rce_b) rq_b <= mem[ra_b];
    end

    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ-1:0]    we;
        logic [NREQ*AW-1:0] addr;
        logic [NREQ*DW-1:0] wdata;
        logic [NREQ-1:0]    ready;
        logic [57:0]        pa;
        logic [57:0]        pb;
        logic [NREQ-1:0]    rsp_v;
        logic [NREQ*DW-1:0] rsp_d;
        int                 cnt;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input int v, we, a3, a2, a1, a0,
                                 input logic [DW-1:0] d3, d2, d1, d0,
                                 input int rdy, ea, aa, input logic [DW-1:0] wda,
                                 input int eb, ab, input logic [DW-1:0] wdb,
                                 input int rv, input logic [DW-1:0] r3, r2, r1, r0,
                                 input int cnt);
        vec_t t;
        t.valid = 4'(v);
        t.we    = 4'(we);
        t.addr  = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        t.wdata = {d3, d2, d1, d0};
        t.ready = 4'(rdy);
        t.pa    = {2'(ea), AW'(aa), AW'(aa), wda};
        t.pb    = {2'(eb), AW'(ab), AW'(ab), wdb};
        t.rsp_v = 4'(rv);
        t.rsp_d = {r3, r2, r1, r0};
        t.cnt   = cnt;
        return t;
    endfunction

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] we,
                         input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
    endtask

    task automatic chk_cnt(input string name, input int exp);
        logic [1:0] e2;
        e2 = (exp > 3) ? 2'd3 : 2'(exp);
        chk({name, " cnt16"}, 160'(conflict_cnt), 160'(16'(exp)));
        chk({name, " cnt2"}, 160'(s_cnt), 160'(e2));
    endtask

    vec_t tv [11];
    logic [NREQ-1:0] prev, exp_rdy;
    int wait_cnt [NREQ];
    int max_wait;

    initial begin
        // ea/eb encode {rce, wce}
        tv[0]  = mkv('b0001, 'b0000, 0, 0, 0, 'h05, Z, Z, Z, Z,
                     'b0001, 'b10, 'h05, Z, 'b00, 0, Z, 'b0000, Z, Z, Z, Z, 0);
        tv[1]  = mkv('b0000, 'b0000, 0, 0, 0, 0, Z, Z, Z, Z,
                     'b0000, 'b00, 0, Z, 'b00, 0, Z, 'b0001, Z, Z, Z, D5, 0);
        tv[2]  = mkv('b0110, 'b0110, 0, 'h20, 'h10, 0, Z, 36'hB, 36'hA, Z,
                     'b0110, 'b01, 'h10, 36'hA, 'b01, 'h20, 36'hB, 'b0000, Z, Z, Z, Z, 0);
        tv[3]  = mkv('b1001, 'b0000, 'h20, 0, 0, 'h10, Z, Z, Z, Z,
                     'b1001, 'b10, 'h20, Z, 'b10, 'h10, Z, 'b0000, Z, Z, Z, Z, 0);
        tv[4]  = mkv('b1000, 'b0000, 'h05, 0, 0, 0, Z, Z, Z, Z,
                     'b1000, 'b10, 'h05, Z, 'b00, 0, Z, 'b1001, 36'hB, Z, Z, 36'hA, 0);
        tv[5]  = mkv('b1001, 'b0001, 'h30, 0, 0, 'h30, Z, Z, Z, 36'h777,
                     'b0001, 'b01, 'h30, 36'h777, 'b00, 0, Z, 'b1000, D5, Z, Z, Z, 0);
        tv[6]  = mkv('b1000, 'b0000, 'h30, 0, 0, 0, Z, Z, Z, Z,
                     'b1000, 'b10, 'h30, Z, 'b00, 0, Z, 'b0000, Z, Z, Z, Z, 1);
        tv[7]  = mkv('b0000, 'b0000, 0, 0, 0, 0, Z, Z, Z, Z,
                     'b0000, 'b00, 0, Z, 'b00, 0, Z, 'b1000, 36'h777, Z, Z, Z, 1);
        tv[8]  = mkv('b0110, 'b0000, 0, 'h05, 'h05, 0, Z, Z, Z, Z,
                     'b0110, 'b10, 'h05, Z, 'b10, 'h05, Z, 'b0000, Z, Z, Z, Z, 1);
        tv[9]  = mkv('b0000, 'b0000, 0, 0, 0, 0, Z, Z, Z, Z,
                     'b0000, 'b00, 0, Z, 'b00, 0, Z, 'b0110, Z, D5, D5, Z, 1);
        tv[10] = mkv('b1000, 'b0000, 'h05, 0, 0, 0, Z, Z, Z, Z,
                     'b1000, 'b10, 'h05, Z, 'b00, 0, Z, 'b0000, Z, Z, Z, Z, 1);

        // Reset: outputs must stay quiet even with every requester asking.
        tb_load   = 1'b1;
        req_valid = '1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 160'(req_ready), 160'(4'b0000));
        chk("reset enables", 160'({rce_a, wce_a, rce_b, wce_b}), 160'(4'b0000));
        chk("reset rsp_valid", 160'(rsp_valid), 160'(4'b0000));
        chk_cnt("reset", 0);
        req_valid = '0;
        tb_load   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tv[i].valid, tv[i].we, tv[i].addr, tv[i].wdata);
            chk($sformatf("v%0d ready", i), 160'(req_ready), 160'(tv[i].ready));
            chk($sformatf("v%0d port_a", i), 160'({rce_a, wce_a, ra_a, wa_a, wd_a}),
                160'(tv[i].pa));
            chk($sformatf("v%0d port_b", i), 160'({rce_b, wce_b, ra_b, wa_b, wd_b}),
                160'(tv[i].pb));
            chk($sformatf("v%0d rsp_valid", i), 160'(rsp_valid), 160'(tv[i].rsp_v));
            chk($sformatf("v%0d rsp_rdata", i), 160'(rsp_rdata), 160'(tv[i].rsp_d));
            chk_cnt($sformatf("v%0d", i), tv[i].cnt);
        end

        // Fairness: everyone reads continuously; pointer starts at 0.
        prev     = 4'b1000;
        max_wait = 0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 4'b0000, {4{10'h005}}, '0);
            exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            chk($sformatf("fair%0d ready", c), 160'(req_ready), 160'(exp_rdy));
            chk($sformatf("fair%0d rsp_valid", c), 160'(rsp_valid), 160'(prev));
            for (int i = 0; i < NREQ; i++) begin
                wait_cnt[i] = req_ready[i] ? 0 : wait_cnt[i] + 1;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            prev = exp_rdy;
        end
        n_tests++;
        if (max_wait > 3) begin
            n_fail++;
            $display("FAIL fair max_wait: got %0d expected <= 3", max_wait);
        end

        // Five write/write conflicts on the same address: 16-bit counter 1->6, 2-bit sticks at 3.
        for (int k = 0; k < 5; k++) begin
            drive(4'b0011, 4'b0011, {10'h0, 10'h0, 10'h040, 10'h040}, {Z, Z, 36'h1, 36'h2});
            exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            chk($sformatf("sat%0d ready", k), 160'(req_ready), 160'(exp_rdy));
            chk_cnt($sformatf("sat%0d", k), 1 + k);
        end
        drive('0, '0, '0, '0);
        chk_cnt("sat end", 6);
        chk("sat end rsp_valid", 160'(rsp_valid), 160'(4'b0000));

        // Reset in flight: the granted read must never respond.
        drive(4'b0100, 4'b0000, {10'h0, 10'h005, 10'h0, 10'h0}, '0);
        chk("mid ready", 160'(req_ready), 160'(4'b0100));
        chk("mid port_a", 160'({rce_a, ra_a}), 160'({1'b1, 10'h005}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid in-reset ready", 160'(req_ready), 160'(4'b0000));
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post-reset rsp_valid", 160'(rsp_valid), 160'(4'b0000));
        chk_cnt("post-reset", 0);
        drive(4'b1111, 4'b0000, {4{10'h005}}, '0);
        chk("post-reset ptr", 160'(req_ready), 160'(4'b0011));
        drive('0, '0, '0, '0);
        chk("post-reset rsp", 160'(rsp_valid), 160'(4'b0011));
        chk("post-reset rdata", 160'(rsp_rdata), 160'({Z, Z, D5, D5}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
